// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: issues one bus transaction per load/store,
// stalls the pipeline until ack or timeout, and aligns/extends load data.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] MEM_ALU_out,
    input  logic [31:0] MEM_Write_data,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_Size,
    input  logic        MEM_Unsigned,
    input  logic        MEM_RegWrite_in,
    output logic        MEM_RegWrite,
    output logic [31:0] MEM_Data_mem_out,
    output logic        mem_stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nx;
    logic               op, is_half, is_word;
    logic               start, capture, abort;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         off_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [31:0]        load_c;

    assign op       = MEM_MemRead | MEM_MemWrite;
    assign is_half  = (MEM_Size == 2'b01);
    assign is_word  = MEM_Size[1];
    assign misalign = op & ((is_half & MEM_ALU_out[0]) |
                            (is_word & (MEM_ALU_out[1:0] != 2'b00)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and pipeline-facing control
    always_comb begin
        state_nx     = state;
        mem_stall    = 1'b0;
        MEM_RegWrite = 1'b0;
        start        = 1'b0;
        capture      = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (op && !misalign) begin
                    mem_stall = 1'b1;
                    start     = 1'b1;
                    state_nx  = BUSY;
                end else begin
                    MEM_RegWrite = MEM_RegWrite_in & ~misalign;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end else if (cnt == CNT_LAST) begin
                    abort    = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                MEM_RegWrite = MEM_RegWrite_in;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Store lane placement; loads enable all lanes
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = MEM_Write_data;
        if (MEM_MemWrite) begin
            case (MEM_Size)
                2'b00: begin
                    be_c    = 4'b0001 << MEM_ALU_out[1:0];
                    wdata_c = {4{MEM_Write_data[7:0]}};
                end
                2'b01: begin
                    be_c    = MEM_ALU_out[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{MEM_Write_data[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = MEM_Write_data;
                end
            endcase
        end
    end

    // Load lane extraction from the lane info latched at issue
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(dmem_rdata >> {off_q, 3'b000});
        h = 16'(dmem_rdata >> {off_q[1], 4'b0000});
        case (size_q)
            2'b00:   load_c = uns_q ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_c = uns_q ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_c = dmem_rdata;
        endcase
    end

    // Bus request, wait counter and load data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_be          <= '0;
            dmem_wdata       <= '0;
            off_q            <= '0;
            size_q           <= '0;
            uns_q            <= 1'b0;
            cnt              <= '0;
            bus_err          <= 1'b0;
            MEM_Data_mem_out <= '0;
        end else begin
            bus_err  <= abort;
            dmem_req <= (state_nx == BUSY);
            if (start) begin
                dmem_addr  <= {MEM_ALU_out[31:2], 2'b00};
                dmem_we    <= MEM_MemWrite;
                dmem_be    <= be_c;
                dmem_wdata <= wdata_c;
                off_q      <= MEM_ALU_out[1:0];
                size_q     <= MEM_Size;
                uns_q      <= MEM_Unsigned;
                cnt        <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state_nx != BUSY) dmem_we <= 1'b0;
            if (capture && !dmem_we) MEM_Data_mem_out <= load_c;
            else if (abort)          MEM_Data_mem_out <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: randomized loads/stores against a bus
// responder with random ack latency; expectations from a behavioural model.
module tb_mem_access;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] MEM_ALU_out, MEM_Write_data;
    logic        MEM_MemRead, MEM_MemWrite;
    logic [1:0]  MEM_Size;
    logic        MEM_Unsigned, MEM_RegWrite_in;
    logic        MEM_RegWrite;
    logic [31:0] MEM_Data_mem_out;
    logic        mem_stall, misalign, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_ALU_out(MEM_ALU_out), .MEM_Write_data(MEM_Write_data),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_Size(MEM_Size), .MEM_Unsigned(MEM_Unsigned),
        .MEM_RegWrite_in(MEM_RegWrite_in), .MEM_RegWrite(MEM_RegWrite),
        .MEM_Data_mem_out(MEM_Data_mem_out), .mem_stall(mem_stall),
        .misalign(misalign), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        berr;
        logic        rw;
        int          stalls;
    } done_exp_t;

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_data = '0;
    int          resp_delay = 1;
    logic [31:0] resp_rdata = '0;
    logic        force_ack = 1'b0;
    logic        rst_active = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(logic [31:0] rd, logic [31:0] a, logic [1:0] sz, logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Bus responder: ack in BUSY cycle resp_delay, stray acks when idle
    int busy_k = 0;
    always @(negedge clk) begin
        logic real_ack;
        if (dmem_req) begin
            busy_k++;
            real_ack   = (busy_k == resp_delay);
            dmem_rdata = real_ack ? resp_rdata : $urandom;
        end else begin
            busy_k     = 0;
            real_ack   = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
        end
        dmem_ack = real_ack | force_ack;
    end

    // Monitor: checks bus request on issue and results in the completion cycle
    logic     prev_req = 1'b0;
    int       stall_cnt = 0;
    logic     cur_valid = 1'b0;
    bus_exp_t cur;
    always @(negedge clk) begin
        if (rst_active) begin
            bus_q.delete();
            done_q.delete();
            prev_req  = 1'b0;
            stall_cnt = 0;
            cur_valid = 1'b0;
        end else begin
            if (mem_stall) stall_cnt++;
            if (dmem_req) begin
                if (!prev_req) begin
                    chk("req_expected", 32'(bus_q.size() != 0), 32'd1);
                    cur_valid = (bus_q.size() != 0);
                    if (cur_valid) cur = bus_q.pop_front();
                end
                if (cur_valid) begin
                    chk("dmem_addr", dmem_addr, cur.addr);
                    chk("dmem_we", 32'(dmem_we), 32'(cur.we));
                    chk("dmem_be", 32'(dmem_be), 32'(cur.be));
                    if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
                    chk("busy_regwrite", 32'(MEM_RegWrite), 32'd0);
                    chk("busy_stall", 32'(mem_stall), 32'd1);
                    chk("busy_bus_err", 32'(bus_err), 32'd0);
                end
            end else if (prev_req) begin
                chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("load_data", MEM_Data_mem_out, d.data);
                    chk("bus_err", 32'(bus_err), 32'(d.berr));
                    chk("done_regwrite", 32'(MEM_RegWrite), 32'(d.rw));
                    chk("stall_cycles", 32'(stall_cnt), 32'(d.stalls));
                    chk("done_stall", 32'(mem_stall), 32'd0);
                end
                stall_cnt = 0;
                cur_valid = 1'b0;
            end else if (bus_err) begin
                chk("stray_bus_err", 32'(bus_err), 32'd0);
            end
            prev_req = dmem_req;
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic rw);
        MEM_MemRead     = rd;
        MEM_MemWrite    = wr;
        MEM_Size        = sz;
        MEM_Unsigned    = uns;
        MEM_ALU_out     = a;
        MEM_Write_data  = wd;
        MEM_RegWrite_in = rw;
    endtask

    task automatic idle_cycle();
        logic rw;
        @(posedge clk); #1;
        rw = 1'($urandom);
        drive(1'b0, 1'b0, 2'($urandom), 1'($urandom), $urandom, $urandom, rw);
        #1;
        chk("idle_regwrite", 32'(MEM_RegWrite), 32'(rw));
        chk("idle_stall", 32'(mem_stall), 32'd0);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic rw,
                         input int dly, input logic [31:0] rdat);
        logic      mis;
        bus_exp_t  b;
        done_exp_t d;
        int        n;
        @(posedge clk); #1;
        resp_delay = dly;
        resp_rdata = rdat;
        mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
        if (!mis) begin
            b.addr  = a & 32'hFFFF_FFFC;
            b.we    = wr;
            b.be    = 4'hF;
            b.wdata = wd;
            if (wr && sz == 2'd0) begin
                b.be    = 4'(1 << a[1:0]);
                b.wdata = (wd & 32'hFF) * 32'h0101_0101;
            end else if (wr && sz == 2'd1) begin
                b.be    = a[1] ? 4'b1100 : 4'b0011;
                b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            end
            if (dly > TMO)  model_data = 32'd0;
            else if (!wr)   model_data = ref_load(rdat, a, sz, uns);
            d.data   = model_data;
            d.berr   = (dly > TMO);
            d.rw     = rw;
            d.stalls = 1 + ((dly > TMO) ? TMO : dly);
            bus_q.push_back(b);
            done_q.push_back(d);
        end
        drive(rd, wr, sz, uns, a, wd, rw);
        #1;
        chk("misalign", 32'(misalign), 32'(mis));
        chk("issue_regwrite", 32'(MEM_RegWrite), 32'd0);
        chk("issue_stall", 32'(mem_stall), 32'(!mis));
        if (!mis) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (mem_stall && n < 30);
            if (n >= 30) chk("op_complete", 32'(mem_stall), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_data", MEM_Data_mem_out, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst_active = 1'b0;

        // Directed cases
        issue(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 1, 3, 32'hDEAD_BEEF);
        issue(1, 0, 2'b00, 0, 32'h0000_0203, 32'h0, 1, 1, 32'h8011_2233);
        issue(1, 0, 2'b00, 1, 32'h0000_0203, 32'h0, 1, TMO, 32'h8011_2233);
        issue(0, 1, 2'b01, 0, 32'h0000_0102, 32'h0000_ABCD, 0, 2, 32'h0);
        issue(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0, 1, 2, 32'h1234_5678);
        issue(1, 1, 2'b11, 0, 32'h0000_0108, 32'hCAFE_F00D, 1, 1, 32'h5555_5555);
        issue(1, 0, 2'b10, 0, 32'h0000_0104, 32'h0, 1, 99, 32'h7777_7777);
        issue(1, 0, 2'b01, 0, 32'h0000_0206, 32'h0, 1, 2, 32'h8001_4321);
        idle_cycle();

        // Reset while BUSY; a later ack must have no effect
        @(posedge clk); #1;
        resp_delay = 99;
        bus_q.push_back('{addr: 32'h300, we: 1'b0, be: 4'hF, wdata: 32'h0});
        drive(1, 0, 2'b10, 0, 32'h0000_0300, 32'h0, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        rst_active = 1'b1;
        rst_n = 1'b0;
        drive(0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
        #1;
        chk("midrst_req", 32'(dmem_req), 32'd0);
        chk("midrst_stall", 32'(mem_stall), 32'd0);
        chk("midrst_data", MEM_Data_mem_out, 32'd0);
        model_data = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        force_ack = 1'b1;
        resp_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(posedge clk); #1;
            chk("postrst_req", 32'(dmem_req), 32'd0);
            chk("postrst_stall", 32'(mem_stall), 32'd0);
            chk("postrst_data", MEM_Data_mem_out, 32'd0);
            chk("postrst_bus_err", 32'(bus_err), 32'd0);
        end
        force_ack = 1'b0;
        @(posedge clk); #1;
        rst_active = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          kind;
            logic        rd, wr;
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz[1]) a[1:0] = 2'b00;
            end
            kind = $urandom_range(0, 3);
            rd   = (kind != 0);
            wr   = (kind == 0) || (kind == 3);
            issue(rd, wr, sz, 1'($urandom), a, $urandom, 1'($urandom),
                  $urandom_range(1, 6), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        repeat (4) idle_cycle();
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 255, maximum number of BUSY cycles to wait for dmem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 MEM_ALU_out  input  32  effective address from EX/MEM.
REQ-005 MEM_Write_data  input  32  store data from EX/MEM.
REQ-006 MEM_MemRead / MEM_MemWrite  input  1 each  load/store request.
REQ-007 MEM_Size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 MEM_Unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-009 MEM_RegWrite_in  input  1  register-write enable from EX/MEM.
REQ-010 MEM_RegWrite  output  1  gated register-write enable to MEM/WB.
REQ-011 MEM_Data_mem_out  output  32  aligned, extended load data to MEM/WB.
REQ-012 mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM while high.
REQ-013 misalign  output  1  combinational flag for a misaligned access.
REQ-014 bus_err  output  1  one-cycle pulse on timeout abort.
REQ-015 dmem_req, dmem_we  output  1 each  bus request, write strobe.
REQ-016 dmem_addr  output  32  word address, {MEM_ALU_out[31:2],2'b00}.
REQ-017 dmem_be  output  4  byte enables; dmem_wdata  output  32  lane-replicated store data.
REQ-018 dmem_rdata  input  32, dmem_ack  input  1  read data and completion from data memory.

Function
REQ-019 op = MEM_MemRead | MEM_MemWrite; MEM_MemWrite takes priority when both are high (dmem_we=1, no capture).
REQ-020 misalign = op & ((half & addr[0]) | (word & addr[1:0]!=0)); misaligned op issues no request, no stall, and forces MEM_RegWrite=0.
REQ-021 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-022 IDLE with aligned op: mem_stall=1 combinationally in the same cycle, next state BUSY.
REQ-023 IDLE without op: mem_stall=0, MEM_RegWrite=MEM_RegWrite_in, state stays IDLE.
REQ-024 BUSY: dmem_req registered high, addr/we/be/wdata stable, mem_stall=1, MEM_RegWrite=0, wait counter increments each cycle.
REQ-025 BUSY with dmem_ack: capture the extracted load result into data register, next state DONE; earliest ack is the first BUSY cycle.
REQ-026 BUSY with counter == TIMEOUT-1 and no ack: bus_err pulses for one cycle, data register loads 0, next state DONE.
REQ-027 DONE: dmem_req=0, mem_stall=0, MEM_RegWrite=MEM_RegWrite_in, MEM_Data_mem_out=data register, next state IDLE unconditionally.
REQ-028 Load extraction: byte lane = addr[1:0], half lane = addr[1]; extend to 32 per MEM_Unsigned; word passes unchanged.
REQ-029 Store: byte be=1<<addr[1:0], wdata={4{data[7:0]}}; half be=addr[1]?1100:0011, wdata={2{data[15:0]}}; word be=1111.
REQ-030 Loads drive dmem_be=1111; dmem_wdata don't-care.
REQ-031 dmem_ack outside BUSY is ignored.
REQ-032 Wait counter clears on entry to BUSY.
REQ-033 MEM_Data_mem_out holds the last captured value outside DONE.

Reset
REQ-034 rst_n low asynchronously forces state IDLE, dmem_req=0, dmem_we=0, bus_err=0, counter=0, data register=0, mem_stall=0.
REQ-035 Reset mid-BUSY drops dmem_req immediately; any later ack is ignored.
REQ-036 First operation after rst_n release starts from IDLE.

Verification
REQ-037 lw at 0x100, ack on 3rd BUSY cycle with rdata 0xDEADBEEF -> stall high 4 cycles, DONE outputs 0xDEADBEEF, RegWrite=1 in DONE only.
REQ-038 lb signed at 0x203, rdata 0x80112233 -> MEM_Data_mem_out=0xFFFFFF80; lbu -> 0x00000080.
REQ-039 sh at 0x102, data 0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-040 lw at 0x101 -> misalign=1, dmem_req never asserted, stall=0, MEM_RegWrite=0.
REQ-041 lw with ack withheld, TIMEOUT=4 -> bus_err pulse after 4 BUSY cycles, data 0, stall released next cycle.
REQ-042 rst_n low during BUSY, ack arriving afterwards -> req low immediately, state IDLE, ack has no effect.
